ads1672_sample_avg: RTL

//  Downstream stage of the ADS1672-EVM controller. It consumes each 24-bit two's-complement ADC word as it is read out.

---
 rtl/ads1672_pkg.sv | 15 +
 rtl/ads1672_sample_avg_sync_fifo.sv | 71 +++++++
 rtl/ads1672_sample_avg.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ads1672_pkg.sv
// Shared types and constants for the ADS1672 sample averaging path.
package ads1672_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PUSH  = 2'd2
  } avg_state_t;

  localparam int ADS1672_DATA_WIDTH = 24;

  localparam logic [ADS1672_DATA_WIDTH-1:0] ADS1672_FS_POS = 24'h7F_FFFF;
  localparam logic [ADS1672_DATA_WIDTH-1:0] ADS1672_FS_NEG = 24'h80_0000;

endpackage

// File: rtl/ads1672_sample_avg_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: rtl/ads1672_sample_avg.sv
// Boxcar decimator for ADS1672 samples feeding a FWFT result FIFO with overflow flag.
// Optional ADS1672_AVG_OVERRANGE_EN tags averages containing a full-scale sample.
//
//   state | meaning
//   IDLE  | no average in progress
//   ACCUM | partial sum held, waiting for more samples
//   PUSH  | completed average written to the FIFO this cycle
import ads1672_pkg::*;

module ads1672_sample_avg #(
  parameter int DATA_WIDTH = ADS1672_DATA_WIDTH,
  parameter int LOG2_AVG   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
`ifdef ADS1672_AVG_OVERRANGE_EN
  output logic                          overrange,
`endif
  input  logic                          clear_overflow
);

  localparam int ACC_W = DATA_WIDTH + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1) << LOG2_AVG;
  localparam bit PASS_THRU = (LOG2_AVG == 0);
`ifdef ADS1672_AVG_OVERRANGE_EN
  localparam int FIFO_W = DATA_WIDTH + 1;
`else
  localparam int FIFO_W = DATA_WIDTH;
`endif

  avg_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    overflow_q, overflow_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic [CNT_W-1:0]        cnt_inc;
  logic [DATA_WIDTH-1:0]   result;
  logic                    sample_ok;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0]       fifo_wdata, fifo_rdata;

  assign sample_ok  = enable & in_valid;
  assign sample_ext = ACC_W'($signed(in_data));
  assign cnt_inc    = cnt_q + CNT_W'(1);
  // Top DATA_WIDTH bits of the sum equal (acc >>> LOG2_AVG) truncated: floor division.
  assign result     = acc_q[LOG2_AVG +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE, PUSH: begin
        fifo_push = (state_q == PUSH);
        if (sample_ok) begin
          acc_d   = sample_ext;
          cnt_d   = CNT_W'(1);
          state_d = PASS_THRU ? PUSH : ACCUM;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (!enable) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (in_valid) begin
          acc_d = acc_q + sample_ext;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) state_d = PUSH;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_pop   = out_valid & out_ready;
  assign overflow_d = clear_overflow ? 1'b0
                    : (overflow_q | (fifo_push & fifo_full & ~fifo_pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ADS1672_AVG_OVERRANGE_EN
  logic fs_hit, flag_q, flag_d;

  assign fs_hit = (in_data == DATA_WIDTH'(ADS1672_FS_POS)) |
                  (in_data == DATA_WIDTH'(ADS1672_FS_NEG));

  // Flag follows the accumulator: reloaded on a new average, OR-ed while accumulating.
  always_comb begin
    flag_d = 1'b0;
    if (sample_ok && state_q != ACCUM) flag_d = fs_hit;
    else if (state_q == ACCUM && enable) flag_d = flag_q | (in_valid & fs_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end

  assign fifo_wdata = {flag_q, result};
  assign out_data   = fifo_rdata[DATA_WIDTH-1:0];
  assign overrange  = fifo_pop & fifo_rdata[DATA_WIDTH];
`else
  assign fifo_wdata = result;
  assign out_data   = fifo_rdata;
`endif

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;

endmodule
